// File: rtl/mac_job_arbiter.sv
// Round-robin arbiter sharing one multiply-accumulate datapath between two
// job requesters; each job is a length N followed by N operand pairs.
module mac_job_arbiter #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN_W  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic [LEN_W-1:0]  len0,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic              valid0,
  output logic              ready0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [LEN_W-1:0]  len1,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  input  logic              valid1,
  output logic              ready1,
  output logic              gnt1,
  output logic [ACC_W-1:0]  result,
  output logic              done,
  output logic              done_id,
  output logic              ovf,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_n;
  logic               owner;
  logic               last;
  logic [LEN_W-1:0]   cnt;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   result_q;
  logic               done_id_q;
  logic               ovf_q;

  logic               win;
  logic [LEN_W-1:0]   win_len;
  logic               sel_valid;
  logic [DATA_W-1:0]  sel_a, sel_b;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W:0]     sum;

  // On a tie the channel not served last wins; `last` resets to 1 so ch0 goes first.
  always_comb begin
    win       = (req0 && req1) ? ~last : req1;
    win_len   = win ? len1 : len0;
    sel_valid = owner ? valid1 : valid0;
    sel_a     = owner ? a1 : a0;
    sel_b     = owner ? b1 : b0;
    prod      = sel_a * sel_b;
    sum       = {1'b0, acc} + (ACC_W+1)'(prod);
  end

  always_comb begin
    state_n = state;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    ready0  = 1'b0;
    ready1  = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1)
          state_n = (win_len != '0) ? RUN : DONE;
      end
      RUN: begin
        gnt0   = ~owner;
        gnt1   = owner;
        ready0 = ~owner;
        ready1 = owner;
        if (sel_valid && cnt == LEN_W'(1))
          state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      cnt       <= '0;
      acc       <= '0;
      result_q  <= '0;
      done_id_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner <= win;
            cnt   <= win_len;
            acc   <= '0;
            ovf_q <= 1'b0;
            if (win_len == '0) begin
              result_q  <= '0;
              done_id_q <= win;
            end
          end
        end
        RUN: begin
          if (sel_valid) begin
            acc <= sum[ACC_W-1:0];
            cnt <= cnt - LEN_W'(1);
            if (sum[ACC_W])
              ovf_q <= 1'b1;
            // Result is published on the final beat so it is valid during DONE.
            if (cnt == LEN_W'(1)) begin
              result_q  <= sum[ACC_W-1:0];
              done_id_q <= owner;
            end
          end
        end
        DONE: last <= owner;
        default: ;
      endcase
    end
  end

  assign result  = result_q;
  assign done_id = done_id_q;
  assign ovf     = ovf_q;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mac_job_arbiter.sv
// Directed and randomized job bench for mac_job_arbiter with a sum-of-products
// reference model evaluated per job.
module tb_mac_job_arbiter;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0, req1, valid0, valid1;
  logic [3:0]  len0, len1;
  logic [7:0]  a0, b0, a1, b1;
  logic        ready0, ready1, gnt0, gnt1, done, done_id, ovf, busy;
  logic [15:0] result;

  int ncmp = 0;
  int nerr = 0;
  int opa[16], opb[16], bub[16];

  mac_job_arbiter #(.DATA_W(8), .ACC_W(16), .LEN_W(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .len0(len0), .a0(a0), .b0(b0), .valid0(valid0), .ready0(ready0), .gnt0(gnt0),
    .req1(req1), .len1(len1), .a1(a1), .b1(b1), .valid1(valid1), .ready1(ready1), .gnt1(gnt1),
    .result(result), .done(done), .done_id(done_id), .ovf(ovf), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected result is the plain sum of products modulo 2^16; ovf if it ever wrapped.
  task automatic model(input int len, output int res, output bit of);
    int s;
    s = 0;
    of = 1'b0;
    for (int k = 0; k < len; k++) begin
      s = s + opa[k] * opb[k];
      if (s >= 65536) begin
        of = 1'b1;
        s = s - 65536;
      end
    end
    res = s;
  endtask

  task automatic drive(input int ch, input logic v, input logic [7:0] a, input logic [7:0] b);
    if (ch == 0) begin valid0 = v; a0 = a; b0 = b; end
    else         begin valid1 = v; a1 = a; b1 = b; end
  endtask

  task automatic do_job(input int ch, input int len, input string tag);
    int  exp_res;
    bit  exp_ovf;
    model(len, exp_res, exp_ovf);
    if (ch == 0) begin req0 = 1'b1; len0 = 4'(len); end
    else         begin req1 = 1'b1; len1 = 4'(len); end
    tick();
    req0 = 1'b0;
    req1 = 1'b0;
    check({tag, ".busy"}, busy, 1);
    check({tag, ".gnt"}, (ch == 0) ? gnt0 : gnt1, (len != 0));
    check({tag, ".ready"}, (ch == 0) ? ready0 : ready1, (len != 0));
    for (int k = 0; k < len; k++) begin
      for (int j = 0; j < bub[k]; j++) begin
        drive(ch, 1'b0, 8'($urandom), 8'($urandom));
        drive(1 - ch, 1'($urandom), 8'($urandom), 8'($urandom));
        tick();
        check({tag, ".bubble_done"}, done, 0);
      end
      drive(ch, 1'b1, 8'(opa[k]), 8'(opb[k]));
      drive(1 - ch, 1'($urandom), 8'($urandom), 8'($urandom));
      check({tag, ".excl"}, {gnt0, gnt1, ready0, ready1}, (ch == 0) ? 4'b1010 : 4'b0101);
      check({tag, ".early_done"}, done, 0);
      tick();
      drive(ch, 1'b0, 8'h00, 8'h00);
    end
    drive(1 - ch, 1'b0, 8'h00, 8'h00);
    check({tag, ".done"}, done, 1);
    check({tag, ".done_id"}, done_id, ch);
    check({tag, ".result"}, result, exp_res);
    check({tag, ".ovf"}, ovf, exp_ovf);
    check({tag, ".gnt_done"}, {gnt0, gnt1, ready0, ready1}, 0);
    tick();
    check({tag, ".done_pulse"}, done, 0);
    check({tag, ".idle"}, busy, 0);
    check({tag, ".result_hold"}, result, exp_res);
  endtask

  task automatic set_scn1();
    opa[0] = 15; opb[0] = 17; opa[1] = 40; opb[1] = 45; opa[2] = 47; opb[2] = 145;
    for (int k = 0; k < 16; k++) bub[k] = 0;
  endtask

  initial begin
    int ids[$];
    reset_n = 1'b0;
    req0 = 0; req1 = 0; valid0 = 0; valid1 = 0;
    len0 = 0; len1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    for (int k = 0; k < 16; k++) begin opa[k] = 0; opb[k] = 0; bub[k] = 0; end
    tick();
    tick();
    check("reset.outs", {ready0, gnt0, ready1, gnt1, done, done_id, ovf, busy}, 0);
    check("reset.result", result, 0);
    reset_n = 1'b1;
    tick();

    // Scenario 1: 8870, no overflow
    set_scn1();
    do_job(0, 3, "s1");
    check("s1.const", result, 16'h22A6);

    // Scenario 2: wraps, 0xFC02
    opa[0] = 255; opb[0] = 255; opa[1] = 255; opb[1] = 255;
    do_job(1, 2, "s2");
    check("s2.const", result, 16'hFC02);
    check("s2.ovf_const", ovf, 1);

    // Scenario 4: two-cycle bubble before beat 2
    set_scn1();
    bub[1] = 2;
    do_job(0, 3, "s4");
    bub[1] = 0;

    // Scenario 6: zero-length job
    do_job(0, 0, "s6");
    check("s6.result0", result, 0);

    // Scenario 5: reset after 2 of 3 beats
    set_scn1();
    req0 = 1'b1; len0 = 4'd3;
    tick();
    req0 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(0, 1'b1, 8'(opa[k]), 8'(opb[k]));
      tick();
    end
    drive(0, 1'b0, 8'h00, 8'h00);
    check("s5.mid_busy", busy, 1);
    reset_n = 1'b0;
    tick();
    check("s5.busy", busy, 0);
    check("s5.gnt0", gnt0, 0);
    check("s5.done", done, 0);
    reset_n = 1'b1;
    tick();
    check("s5.no_done", done, 0);
    do_job(0, 3, "s5rerun");
    check("s5.const", result, 16'h22A6);

    // Scenario 3: fresh reset with both requests held, len=1 each
    reset_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; len0 = 4'd1; len1 = 4'd1;
    drive(0, 1'b1, 8'd3, 8'd4);
    drive(1, 1'b1, 8'd5, 8'd6);
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 14 && ids.size() < 4; c++) begin
      tick();
      check("s3.excl", gnt0 & gnt1, 0);
      if (done) begin
        ids.push_back(int'(done_id));
        check("s3.result", result, done_id ? 30 : 12);
      end
    end
    check("s3.count", ids.size(), 4);
    for (int i = 0; i < 4; i++)
      check("s3.order", (i < ids.size()) ? ids[i] : -1, i % 2);
    req0 = 1'b0; req1 = 1'b0;
    drive(0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 8'h00, 8'h00);
    for (int c = 0; c < 4; c++) tick();
    check("s3.idle", busy, 0);

    // Randomized jobs with random bubbles and noise on the idle channel
    for (int n = 0; n < 40; n++) begin
      int ch, len;
      ch  = int'($urandom_range(0, 1));
      len = int'($urandom_range(0, 15));
      for (int k = 0; k < 16; k++) begin
        opa[k] = int'($urandom_range(0, 255));
        opb[k] = int'($urandom_range(0, 255));
        bub[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      end
      do_job(ch, len, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/mac_job_arbiter.md
Name: mac_job_arbiter

Overview:
- Shares one 8x8 multiply / 16-bit accumulate datapath between two requesters.
- Each requester submits a job: a length N, then N operand pairs streamed over a valid/ready handshake.
- The block arbitrates round-robin between the two channels and sequences the accumulator (clear, accumulate N beats, publish result).
- It sits between operand producers and result consumers, replacing direct per-user MAC instances.

Parameters:
- DATA_W, 8, operand width of A and B.
- ACC_W, 16, accumulator/result width; must be at least 2*DATA_W.
- LEN_W, 4, job length field width (N = 0..2^LEN_W-1).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset.
- req0  in  1  channel 0 job request (level).
- len0  in  LEN_W  channel 0 beat count, sampled on grant.
- a0  in  DATA_W  channel 0 operand A.
- b0  in  DATA_W  channel 0 operand B.
- valid0  in  1  channel 0 operand pair valid.
- ready0  out  1  channel 0 operand accepted when valid0&ready0.
- gnt0  out  1  channel 0 owns the datapath.
- req1, len1, a1, b1, valid1, ready1, gnt1: same set of ports for channel 1.
- result  out  ACC_W  final accumulated value of the last completed job.
- done  out  1  one-cycle pulse: result valid for the job just finished.
- done_id  out  1  channel that owned the finished job.
- ovf  out  1  accumulator wrapped at least once during the reported job.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (reset_n=0 at a clock edge): state IDLE; all outputs 0; accumulator 0; beat counter 0; priority pointer set so ch0 wins the first tie. Reset mid-job drops the job with no done pulse.
- IDLE: if neither req is high, stay. Otherwise pick a winner:
  - Only one req high: that channel wins.
  - Both high: the channel not served last wins.
  - On the winner: latch owner and len, clear accumulator and ovf.
  - Go to RUN if len != 0, else go to DONE.
- RUN:
  - gnt_owner=1 and ready_owner=1; non-owner gnt/ready=0.
  - Each beat with valid_owner=1: acc <= (acc + a*b) mod 2^ACC_W, using a full 2*DATA_W-bit product zero-extended to ACC_W.
  - ovf is set if that add carries out of ACC_W; it stays set for the rest of the job.
  - The counter decrements per accepted beat. valid low inserts a bubble: acc and counter hold.
  - When the final beat is accepted, go to DONE.
- DONE (exactly one cycle):
  - done=1, done_id=owner.
  - result = final acc including the last beat; result holds until the next DONE.
  - ovf reports the job; gnt/ready=0.
  - Priority pointer updates to the served channel. Next state is IDLE.
- Latency: req sampled high in IDLE at edge t gives gnt/ready high from cycle t+1. With no bubbles, the last beat is accepted at t+N and done fires at t+N+1. A len=0 job gives done at t+1, result 0. Minimum occupancy is N+2 cycles per job.
- req deassertion during RUN is ignored; the job runs until N beats complete.
- A req still high when the block returns to IDLE is treated as a new job.
- valid on a non-granted channel is ignored and never accepted.
- result, done_id and ovf are registered outputs; done is low in all states except DONE.

Test Plan:
1. Reset, then req0=1, len0=3, beats (15,17),(40,45),(47,145) back-to-back -> done at req+4, result=0x22A6 (8870), done_id=0, ovf=0.
2. req1=1, len1=2, beats (255,255),(255,255) -> result=0xFC02 (130050 mod 65536), ovf=1, done_id=1.
3. req0 and req1 both held high from reset, len=1 each -> grant order ch0, ch1, ch0, ch1; no cycle with gnt0&gnt1; done_id alternates 0,1,0,1.
4. ch0 len=3 with valid0 low for 2 cycles between beats 1 and 2 (operands as in scenario 1) -> result=0x22A6, done delayed by exactly 2 cycles versus scenario 1.
5. reset_n pulled low for one cycle after 2 of 3 beats accepted -> next cycle busy=0, gnt0=0, no done pulse. A rerun of scenario 1 then yields result 0x22A6.
6. req0=1, len0=0 -> done one cycle after grant, result=0, ovf=0, ready0 never asserted.
